uart_host_if: RTL and testbench
===============================

Name: uart_host_if

Overview:
Parametrised CPU host interface for the UART. It replaces the single C_nD select with an address-decoded register file of data, status, control and interrupt-enable registers. The CPU strobes are asynchronous, so the block synchronises them and emits single-cycle push/pop strobes to the Tx/Rx FIFOs. It also holds sticky error flags with clear-on-read and write-1-to-clear, a maskable interrupt, and a self-clearing soft reset. It sits between the external CPU bus and the Tx/Rx FIFOs and baud/framing blocks.

Parameters:
DW, 8, data bus and register width; legal values are 8 or more; bits above 7 read 0 except in CR/IER.
AW, 2, register address width; addresses 0-3 are decoded and higher addresses are unmapped.
SYNC_STAGES, 2, flip-flop stages on n_CS/n_RD/n_WR; legal values are 2 or more.

Ports:
CLK50MHZ  in  1  system clock
n_RST  in  1  reset, asynchronous, active-low
n_CS  in  1  chip select, active-low, asynchronous to CLK50MHZ
n_RD  in  1  read strobe, active-low, asynchronous
n_WR  in  1  write strobe, active-low, asynchronous
ADDR  in  AW  register select
DATA_IN  in  DW  CPU write data
DATA_OUT  out  DW  CPU read data
DATA_Rx  in  DW  head of Rx FIFO
Rx_RDY  in  1  Rx FIFO non-empty
Rx_POP  out  1  one-cycle pop strobe to Rx FIFO
DATA_Tx  out  DW  data to Tx FIFO, valid while Tx_PUSH=1
Tx_PUSH  out  1  one-cycle push strobe to Tx FIFO
Tx_RDY  in  1  Tx FIFO can accept a character
PE_Fg, FE_Fg, OE_Fg  in  1 each  parity/framing/overrun error pulses or levels from Rx
DATA_CR  out  DW  current control register
IRQ  out  1  interrupt request, active-high, registered
I_RST  out  1  one-cycle soft-reset pulse to the other UART blocks

Behaviour:
- Reset is asynchronous, active-low (n_RST=0). It clears every output and register to 0 and clears the synchroniser flops to 1 (inactive).
- Strobe synchronisation:
  - rd_act = !n_CS & !n_RD and wr_act = !n_CS & !n_WR are each formed from the SYNC_STAGES-synchronised strobes.
  - A rise of the synchronised level is "start"; a fall is "end".
- Bus contract: ADDR and DATA_IN must be stable from strobe assertion until end. The block samples them at start.
- If rd_act and wr_act are both active, the access is ignored: no register change and no strobes.
- Register map, read:
  - 0 returns DATA_Rx.
  - 1 returns SR.
  - 2 returns CR.
  - 3 returns IER.
  - Unmapped addresses return 0.
- Register map, write:
  - 0 = Tx data.
  - 1 = write-1-to-clear on SR[5:2].
  - 2 = CR.
  - 3 = IER.
  - Unmapped addresses are ignored.
- SR bits:
  - [0] Rx_RDY, live.
  - [1] Tx_RDY, live.
  - [2] PE, sticky.
  - [3] FE, sticky.
  - [4] OE, sticky.
  - [5] TO (Tx overflow), sticky.
  - [6] IRQ.
  - [7] and above read 0.
- Sticky flags set on any cycle in which their input is 1. When a set and a clear happen in the same cycle, set wins.
- Read timing:
  - At start, DATA_OUT loads the selected value and holds it until end.
  - At end, DATA_OUT returns to 0.
- Read of address 0:
  - If Rx_RDY was 1 at start, Rx_POP pulses for 1 cycle at end.
  - If Rx_RDY was 0 at start, DATA_OUT returns 0 and there is no pop.
- Read of address 1: at end, SR[5:2] clears, except any bit being set in that same cycle.
- Write timing: the write commits in the cycle of start.
- Write to address 0:
  - If Tx_RDY=1, DATA_Tx takes DATA_IN and Tx_PUSH pulses in that same cycle. DATA_Tx returns to 0 the next cycle.
  - If Tx_RDY=0, the data is dropped and TO is set. There is no push.
- Write to address 2:
  - CR updates and DATA_CR follows 1 cycle after commit.
  - If DATA_IN[7]=1, this is a soft reset:
    - CR, IER, SR sticky bits and IRQ clear the next cycle.
    - I_RST pulses for exactly 1 cycle.
    - CR[7] is never observable as 1.
- IRQ is registered as |(SR[5:0] & IER[5:0]), 1 cycle after the source changes.
- Latencies:
  - Strobe assertion to start is SYNC_STAGES+1 cycles.
  - At most one push or pop occurs per CPU access, whatever the strobe length.
- If reset asserts mid-access, the access is aborted. After release, a strobe already held low is not treated as a new start until it deasserts and reasserts.

Test Plan:
1. Write 0x5A to address 0 with Tx_RDY=1 -> exactly one Tx_PUSH pulse with DATA_Tx=0x5A, SYNC_STAGES+1 cycles after n_WR falls. Repeat with Tx_RDY=0 -> no push, SR=0x20 read at address 1.
2. Rx_RDY=1, DATA_Rx=0xC3, hold a read of address 0 for 10 cycles -> DATA_OUT=0xC3 throughout and a single Rx_POP at end. Read again with Rx_RDY=0 -> DATA_OUT=0 and no pop.
3. Pulse PE_Fg for 1 cycle, then read address 1 twice -> first read returns 0x04 (with live bits), second returns 0x00. Assert FE_Fg during the end cycle of a status read -> FE remains set.
4. Write IER=0x08, then pulse FE_Fg -> IRQ=1 one cycle later. Write 0x08 to address 1 -> IRQ falls the cycle after.
5. Write CR=0x15 -> DATA_CR=0x15. Write CR=0x80 -> single I_RST pulse, then DATA_CR=0, IER=0, IRQ=0.
6. Assert n_RST during a held read, then release with n_RD still low -> no Rx_POP and DATA_OUT=0 until the strobe deasserts and a new access starts.

Source files
------------

// File: rtl/uart_host_if.sv
// uart_host_if: CPU host register interface for the UART.
// Synchronises the asynchronous CPU strobes and decodes a four-entry register file:
// 0 = Rx/Tx data, 1 = status (SR), 2 = control (CR), 3 = interrupt enable (IER).
// It also issues one-cycle Tx push / Rx pop strobes, keeps sticky error flags,
// drives a maskable IRQ and generates a one-cycle soft-reset pulse.
// Ports:
//   CLK50MHZ, n_RST              clock, async active-low reset
//   n_CS, n_RD, n_WR             async active-low CPU strobes
//   ADDR, DATA_IN, DATA_OUT      CPU register bus
//   DATA_Rx, Rx_RDY, Rx_POP      Rx FIFO head, non-empty flag, pop strobe
//   DATA_Tx, Tx_PUSH, Tx_RDY     Tx FIFO data, push strobe, can-accept flag
//   PE_Fg, FE_Fg, OE_Fg          receiver error inputs
//   DATA_CR, IRQ, I_RST          control register, interrupt, soft reset pulse
module uart_host_if #(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          CLK50MHZ,
  input  logic          n_RST,
  input  logic          n_CS,
  input  logic          n_RD,
  input  logic          n_WR,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] DATA_IN,
  output logic [DW-1:0] DATA_OUT,
  input  logic [DW-1:0] DATA_Rx,
  input  logic          Rx_RDY,
  output logic          Rx_POP,
  output logic [DW-1:0] DATA_Tx,
  output logic          Tx_PUSH,
  input  logic          Tx_RDY,
  input  logic          PE_Fg,
  input  logic          FE_Fg,
  input  logic          OE_Fg,
  output logic [DW-1:0] DATA_CR,
  output logic          IRQ,
  output logic          I_RST
);

  // Edge detection stays disabled until the synchronisers hold real pin values.
  localparam int unsigned SETTLE = SYNC_STAGES + 1;
  localparam int unsigned CW     = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] r_cs_sync, r_rd_sync, r_wr_sync;
  logic                   r_rd_prev, r_wr_prev;
  logic [CW-1:0]          r_settle;
  logic                   r_rd_busy, r_rd_sr, r_rd_pop;
  logic [DW-1:0]          r_data_out, r_tx_data, r_cr, r_ier;
  logic                   r_rx_pop, r_tx_push, r_irq, r_i_rst;
  logic [3:0]             r_sticky;

  logic          w_rd_lvl, w_wr_lvl, w_live;
  logic          w_rd_start, w_wr_start, w_rd_end;
  logic          w_mapped;
  logic [1:0]    w_a;
  logic [DW-1:0] w_sr, w_rd_val, w_cr_wdata;
  logic          w_wr_tx, w_wr_w1c, w_wr_cr, w_wr_ier, w_srst, w_to_set;
  logic [3:0]    w_clr, w_sticky_nxt;
  logic          w_irq_nxt;

  // Only addresses 0-3 are mapped; wider address buses need their upper bits zero.
  generate
    if (AW > 2) begin : g_dec
      assign w_mapped = ~|ADDR[AW-1:2];
    end else begin : g_nodec
      assign w_mapped = 1'b1;
    end
  endgenerate

  assign w_a = ADDR[1:0];

  // Strobe synchronisers, reset to the inactive level.
  always_ff @(posedge CLK50MHZ or negedge n_RST) begin
    if (!n_RST) begin
      r_cs_sync <= '1;
      r_rd_sync <= '1;
      r_wr_sync <= '1;
    end else begin
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], n_CS};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], n_RD};
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], n_WR};
    end
  end

  assign w_rd_lvl = ~r_cs_sync[SYNC_STAGES-1] & ~r_rd_sync[SYNC_STAGES-1];
  assign w_wr_lvl = ~r_cs_sync[SYNC_STAGES-1] & ~r_wr_sync[SYNC_STAGES-1];
  assign w_live   = (r_settle == CW'(SETTLE));

  // A strobe still held low through reset release is seen as already active, not as a start.
  always_ff @(posedge CLK50MHZ or negedge n_RST) begin
    if (!n_RST) begin
      r_rd_prev <= 1'b0;
      r_wr_prev <= 1'b0;
      r_settle  <= '0;
    end else begin
      r_rd_prev <= w_rd_lvl;
      r_wr_prev <= w_wr_lvl;
      if (!w_live) r_settle <= r_settle + CW'(1);
    end
  end

  // Simultaneous read and write strobes suppress both accesses.
  assign w_rd_start = w_live & w_rd_lvl & ~r_rd_prev & ~w_wr_lvl;
  assign w_wr_start = w_live & w_wr_lvl & ~r_wr_prev & ~w_rd_lvl;
  assign w_rd_end   = w_live & ~w_rd_lvl & r_rd_prev & r_rd_busy;

  // Status word and read mux; bits above 7 read 0 except CR/IER.
  always_comb begin
    w_sr      = '0;
    w_sr[0]   = Rx_RDY;
    w_sr[1]   = Tx_RDY;
    w_sr[5:2] = r_sticky;
    w_sr[6]   = r_irq;
    w_rd_val  = '0;
    if (w_mapped) begin
      case (w_a)
        2'd0:    if (Rx_RDY) w_rd_val[7:0] = DATA_Rx[7:0];
        2'd1:    w_rd_val = w_sr;
        2'd2:    w_rd_val = r_cr;
        default: w_rd_val = r_ier;
      endcase
    end
  end

  // Write decode, sticky-flag update (set wins over clear) and IRQ next value.
  always_comb begin
    w_wr_tx    = w_wr_start & w_mapped & (w_a == 2'd0);
    w_wr_w1c   = w_wr_start & w_mapped & (w_a == 2'd1);
    w_wr_cr    = w_wr_start & w_mapped & (w_a == 2'd2);
    w_wr_ier   = w_wr_start & w_mapped & (w_a == 2'd3);
    w_srst     = w_wr_cr & DATA_IN[7];
    w_to_set   = w_wr_tx & ~Tx_RDY;
    w_cr_wdata = DATA_IN;
    w_cr_wdata[7] = 1'b0;
    w_clr      = '0;
    if (w_wr_w1c)            w_clr = w_clr | DATA_IN[5:2];
    if (w_rd_end && r_rd_sr) w_clr = 4'hF;
    if (w_srst)              w_clr = 4'hF;
    w_sticky_nxt = (r_sticky & ~w_clr) | {w_to_set, OE_Fg, FE_Fg, PE_Fg};
    w_irq_nxt    = ~w_srst & (|(w_sr[5:0] & r_ier[5:0]));
  end

  // Read data hold, Rx pop at end of access, Tx push at write commit.
  always_ff @(posedge CLK50MHZ or negedge n_RST) begin
    if (!n_RST) begin
      r_rd_busy  <= 1'b0;
      r_rd_sr    <= 1'b0;
      r_rd_pop   <= 1'b0;
      r_data_out <= '0;
      r_rx_pop   <= 1'b0;
      r_tx_push  <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_rx_pop  <= 1'b0;
      r_tx_push <= 1'b0;
      r_tx_data <= '0;
      if (w_rd_start) begin
        r_rd_busy  <= 1'b1;
        r_rd_sr    <= w_mapped & (w_a == 2'd1);
        r_rd_pop   <= w_mapped & (w_a == 2'd0) & Rx_RDY;
        r_data_out <= w_rd_val;
      end else if (r_rd_busy && w_rd_lvl && w_wr_lvl) begin
        r_rd_busy  <= 1'b0;
        r_data_out <= '0;
      end else if (w_rd_end) begin
        r_rd_busy  <= 1'b0;
        r_data_out <= '0;
        r_rx_pop   <= r_rd_pop;
      end
      if (w_wr_tx && Tx_RDY) begin
        r_tx_push <= 1'b1;
        r_tx_data <= DATA_IN;
      end
    end
  end

  // Control, interrupt-enable, sticky flags, IRQ and soft reset.
  always_ff @(posedge CLK50MHZ or negedge n_RST) begin
    if (!n_RST) begin
      r_cr     <= '0;
      r_ier    <= '0;
      r_sticky <= '0;
      r_irq    <= 1'b0;
      r_i_rst  <= 1'b0;
    end else begin
      r_sticky <= w_sticky_nxt;
      r_irq    <= w_irq_nxt;
      r_i_rst  <= w_srst;
      if (w_srst) begin
        r_cr  <= '0;
        r_ier <= '0;
      end else begin
        if (w_wr_cr)  r_cr  <= w_cr_wdata;
        if (w_wr_ier) r_ier <= DATA_IN;
      end
    end
  end

  assign DATA_OUT = r_data_out;
  assign Rx_POP   = r_rx_pop;
  assign DATA_Tx  = r_tx_data;
  assign Tx_PUSH  = r_tx_push;
  assign DATA_CR  = r_cr;
  assign IRQ      = r_irq;
  assign I_RST    = r_i_rst;

endmodule

// File: tb/tb_uart_host_if.sv
// tb_uart_host_if: directed self-checking bench for uart_host_if.
module tb_uart_host_if;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       n_cs = 1'b1, n_rd = 1'b1, n_wr = 1'b1;
  logic [1:0] addr = '0;
  logic [7:0] data_in = '0, data_out, data_rx = '0, data_tx, data_cr;
  logic       rx_rdy = 1'b0, rx_pop, tx_push, tx_rdy = 1'b1;
  logic       pe = 1'b0, fe = 1'b0, oe = 1'b0, irq, i_rst;

  int n_checks = 0;
  int n_errors = 0;
  int push_cnt = 0, pop_cnt = 0, irst_cnt = 0;
  logic cr7_seen = 1'b0;
  logic [7:0] d;
  int p0;

  uart_host_if #(.DW(8), .AW(2), .SYNC_STAGES(2)) dut (
    .CLK50MHZ(clk), .n_RST(n_rst), .n_CS(n_cs), .n_RD(n_rd), .n_WR(n_wr),
    .ADDR(addr), .DATA_IN(data_in), .DATA_OUT(data_out),
    .DATA_Rx(data_rx), .Rx_RDY(rx_rdy), .Rx_POP(rx_pop),
    .DATA_Tx(data_tx), .Tx_PUSH(tx_push), .Tx_RDY(tx_rdy),
    .PE_Fg(pe), .FE_Fg(fe), .OE_Fg(oe),
    .DATA_CR(data_cr), .IRQ(irq), .I_RST(i_rst)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (tx_push) push_cnt++;
    if (rx_pop)  pop_cnt++;
    if (i_rst)   irst_cnt++;
    if (data_cr[7]) cr7_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle(input int n);
    n_cs = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_begin(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    addr = a; data_in = v; n_cs = 1'b0; n_wr = 1'b0;
  endtask

  task automatic rd_begin(input logic [1:0] a);
    @(negedge clk);
    addr = a; n_cs = 1'b0; n_rd = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] v);
    wr_begin(a, v);
    repeat (5) @(negedge clk);
    bus_idle(5);
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] v);
    rd_begin(a);
    repeat (4) @(negedge clk);
    v = data_out;
    bus_idle(5);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_tx_push",  32'(tx_push),  32'h0);
    chk("rst_data_cr",  32'(data_cr),  32'h0);
    chk("rst_irq",      32'(irq),      32'h0);
    chk("rst_i_rst",    32'(i_rst),    32'h0);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);

    // 1: Tx write, push latency SYNC_STAGES+1
    p0 = push_cnt;
    wr_begin(2'd0, 8'h5A);
    @(negedge clk); chk("tx_push_c1", 32'(tx_push), 32'h0);
    @(negedge clk); chk("tx_push_c2", 32'(tx_push), 32'h0);
    @(negedge clk); chk("tx_push_c3", 32'(tx_push), 32'h1);
    chk("tx_data_c3", 32'(data_tx), 32'h5A);
    @(negedge clk); chk("tx_push_c4", 32'(tx_push), 32'h0);
    chk("tx_data_c4", 32'(data_tx), 32'h0);
    repeat (4) @(negedge clk);
    bus_idle(5);
    chk("tx_push_once", 32'(push_cnt - p0), 32'd1);

    tx_rdy = 1'b0; rx_rdy = 1'b0;
    p0 = push_cnt;
    cpu_wr(2'd0, 8'h11);
    chk("tx_full_nopush", 32'(push_cnt - p0), 32'd0);
    cpu_rd(2'd1, d);
    chk("sr_to", 32'(d), 32'h20);
    tx_rdy = 1'b1;

    // 2: held Rx read, single pop at end
    rx_rdy = 1'b1; data_rx = 8'hC3;
    p0 = pop_cnt;
    rd_begin(2'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 3) chk("rx_hold", 32'(data_out), 32'hC3);
    end
    bus_idle(6);
    chk("rx_pop_once", 32'(pop_cnt - p0), 32'd1);
    chk("rx_out_end",  32'(data_out), 32'h0);
    rx_rdy = 1'b0;
    p0 = pop_cnt;
    cpu_rd(2'd0, d);
    chk("rx_empty_data", 32'(d), 32'h0);
    chk("rx_empty_nopop", 32'(pop_cnt - p0), 32'd0);

    // 3: sticky PE with clear-on-read; FE set during clear wins
    @(negedge clk); pe = 1'b1;
    @(negedge clk); pe = 1'b0;
    cpu_rd(2'd1, d); chk("sr_pe_first",  32'(d), 32'h06);
    cpu_rd(2'd1, d); chk("sr_pe_second", 32'(d), 32'h02);
    rd_begin(2'd1);
    repeat (4) @(negedge clk);
    chk("sr_live", 32'(data_out), 32'h02);
    n_cs = 1'b1; n_rd = 1'b1;
    repeat (2) @(negedge clk);
    fe = 1'b1;
    @(negedge clk);
    fe = 1'b0;
    repeat (3) @(negedge clk);
    cpu_rd(2'd1, d); chk("sr_fe_setwins", 32'(d), 32'h0A);

    // 4: IER mask and IRQ timing
    cpu_wr(2'd3, 8'h08);
    @(negedge clk); fe = 1'b1;
    @(negedge clk); fe = 1'b0;
    chk("irq_lat0", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_lat1", 32'(irq), 32'h1);
    wr_begin(2'd1, 8'h08);
    repeat (3) @(negedge clk);
    chk("irq_w1c_c3", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_w1c_c4", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    bus_idle(5);
    cpu_rd(2'd3, d); chk("ier_read", 32'(d), 32'h08);

    // 5: CR write and soft reset
    cpu_wr(2'd2, 8'h15);
    chk("cr_write", 32'(data_cr), 32'h15);
    cpu_wr(2'd3, 8'h10);
    @(negedge clk); oe = 1'b1;
    @(negedge clk); oe = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq_oe", 32'(irq), 32'h1);
    p0 = irst_cnt;
    cpu_wr(2'd2, 8'h80);
    chk("srst_pulse", 32'(irst_cnt - p0), 32'd1);
    chk("srst_cr",    32'(data_cr), 32'h0);
    chk("srst_irq",   32'(irq), 32'h0);
    cpu_rd(2'd3, d); chk("srst_ier", 32'(d), 32'h0);
    cpu_rd(2'd1, d); chk("srst_sr",  32'(d), 32'h02);
    chk("cr7_never", 32'(cr7_seen), 32'h0);

    // 6: reset during a held read
    rx_rdy = 1'b1; data_rx = 8'hC3;
    p0 = pop_cnt;
    rd_begin(2'd0);
    repeat (4) @(negedge clk);
    chk("abort_pre", 32'(data_out), 32'hC3);
    n_rst = 1'b0;
    @(negedge clk);
    chk("abort_rst", 32'(data_out), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_held_data", 32'(data_out), 32'h0);
    chk("abort_held_pop",  32'(pop_cnt - p0), 32'd0);
    bus_idle(6);
    chk("abort_rel_data", 32'(data_out), 32'h0);
    chk("abort_rel_pop",  32'(pop_cnt - p0), 32'd0);
    cpu_rd(2'd0, d);
    chk("abort_new_read", 32'(d), 32'hC3);
    chk("abort_new_pop",  32'(pop_cnt - p0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
